issue_queue_mp: RTL and testbench

- Parametrised multi-push / multi-pop in-order issue queue.
- Sits between decode and issue as the next-generation replacement for the fixed 4-in / 2-out queue.
- Generalises push width, pop width, depth and element width; adds flush, all-or-nothing push acceptance, clipped pop and free-slot reporting.
- Storage is a circular buffer; arbitrary (non-power-of-two) depth is supported.

---
 rtl/issue_queue_mp_if.sv | 23 ++
 rtl/issue_queue_mp.sv | 89 ++++++++
 tb/tb_issue_queue_mp.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_mp_if.sv
// Decode-to-issue handshake bundle for issue_queue_mp: push group in, head window out.
interface issue_queue_mp_if #(
    parameter int PUSH_W = 4,
    parameter int POP_W  = 2,
    parameter int ELEM_W = 64
);
    logic [PUSH_W*ELEM_W-1:0]     push_data;
    logic [$clog2(PUSH_W+1)-1:0]  push_num;
    logic                         push_ack;
    logic [$clog2(POP_W+1)-1:0]   pop_num;
    logic [POP_W*ELEM_W-1:0]      out_data;
    logic [$clog2(POP_W+1)-1:0]   out_num;

    modport master (
        output push_data, push_num, pop_num,
        input  push_ack, out_data, out_num
    );

    modport slave (
        input  push_data, push_num, pop_num,
        output push_ack, out_data, out_num
    );
endinterface

// File: rtl/issue_queue_mp.sv
// Multi-push / multi-pop in-order issue queue on a circular buffer of arbitrary depth.
// Optional sticky protocol-error detection is enabled by defining IQ_ERRCHK_EN.
module issue_queue_mp #(
    parameter int DEPTH  = 8,
    parameter int PUSH_W = 4,
    parameter int POP_W  = 2,
    parameter int ELEM_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    issue_queue_mp_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] free,
    output logic                       err
);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ONW = $clog2(POP_W+1);

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [ELEM_W-1:0] mem [DEPTH];
    int                out_cnt;
    int                pop_eff;
    int                push_eff;

    // Operands never exceed DEPTH, so one conditional subtract keeps the pointer in range.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input int n);
        int s;
        s = int'(ptr) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return s[PW-1:0];
    endfunction

    assign free = CW'(DEPTH) - count;

    always_comb begin
        out_cnt      = (int'(count) < POP_W) ? int'(count) : POP_W;
        bus.out_num  = ONW'(out_cnt);
        bus.push_ack = int'(bus.push_num) <= int'(free);
        pop_eff      = (int'(bus.pop_num) < out_cnt) ? int'(bus.pop_num) : out_cnt;
        push_eff     = bus.push_ack ? int'(bus.push_num) : 0;
    end

    // Head window comes only from registered state; unused slots read as zero.
    always_comb begin
        bus.out_data = '0;
        for (int j = 0; j < POP_W; j++) begin
            if (j < out_cnt) bus.out_data[j*ELEM_W +: ELEM_W] = mem[wrap_add(head, j)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= wrap_add(head, pop_eff);
            tail  <= wrap_add(tail, push_eff);
            count <= CW'(int'(count) - pop_eff + push_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.push_ack && !flush) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (i < int'(bus.push_num)) mem[wrap_add(tail, i)] <= bus.push_data[i*ELEM_W +: ELEM_W];
            end
        end
    end

`ifdef IQ_ERRCHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (!flush && (!bus.push_ack || int'(bus.pop_num) > out_cnt)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_issue_queue_mp.sv
// Directed self-checking bench for issue_queue_mp (DEPTH=8 main instance, DEPTH=7 wrap instance).
module tb_issue_queue_mp;
    localparam int PNW = 3;
    localparam int ONW = 2;
`ifdef IQ_ERRCHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush8, flush7;
    logic [3:0] count8, free8, count7, free7;
    logic       err8, err7;
    int         tests = 0;
    int         fails = 0;

    issue_queue_mp_if #(.PUSH_W(4), .POP_W(2), .ELEM_W(64)) b8 ();
    issue_queue_mp_if #(.PUSH_W(4), .POP_W(2), .ELEM_W(64)) b7 ();

    issue_queue_mp #(.DEPTH(8), .PUSH_W(4), .POP_W(2), .ELEM_W(64)) d8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(b8),
        .count(count8), .free(free8), .err(err8));

    issue_queue_mp #(.DEPTH(7), .PUSH_W(4), .POP_W(2), .ELEM_W(64)) d7 (
        .clk(clk), .rst_n(rst_n), .flush(flush7), .bus(b7),
        .count(count7), .free(free7), .err(err7));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int pn, input logic [63:0] base, input int popn, input logic fl);
        b8.push_num = PNW'(pn);
        for (int i = 0; i < 4; i++) b8.push_data[i*64 +: 64] = base + 64'(i);
        b8.pop_num = ONW'(popn);
        flush8 = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] slot8(input int j);
        return b8.out_data[j*64 +: 64];
    endfunction

    function automatic logic [63:0] slot7(input int j);
        return b7.out_data[j*64 +: 64];
    endfunction

    initial begin
        logic [63:0] q[$];
        logic [63:0] seq;
        int          exp_on, pops;
        logic        exp_ack;

        rst_n = 1'b0;
        flush8 = 1'b0;
        flush7 = 1'b0;
        b8.push_num = '0; b8.pop_num = '0; b8.push_data = '0;
        b7.push_num = '0; b7.pop_num = '0; b7.push_data = '0;
        #12;
        checkOutput("reset count", 64'(count8), 64'd0);
        checkOutput("reset free", 64'(free8), 64'd8);
        checkOutput("reset out_num", 64'(b8.out_num), 64'd0);
        checkOutput("reset out_data", b8.out_data[63:0] | b8.out_data[127:64], 64'd0);
        checkOutput("reset err", 64'(err8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic push of a full group
        applyStimulus(4, 64'hA0, 0, 1'b0);
        checkOutput("t1 ack", 64'(b8.push_ack), 64'd1);
        step();
        checkOutput("t1 count", 64'(count8), 64'd4);
        checkOutput("t1 free", 64'(free8), 64'd4);
        checkOutput("t1 out_num", 64'(b8.out_num), 64'd2);
        checkOutput("t1 slot0", slot8(0), 64'hA0);
        checkOutput("t1 slot1", slot8(1), 64'hA1);

        // Push and pop together; free is not credited by the pop
        applyStimulus(4, 64'hB0, 2, 1'b0);
        checkOutput("t2 ack", 64'(b8.push_ack), 64'd1);
        step();
        checkOutput("t2 count", 64'(count8), 64'd6);
        checkOutput("t2 slot0", slot8(0), 64'hA2);
        checkOutput("t2 slot1", slot8(1), 64'hA3);

        // Rejected group writes nothing, pop still applies
        applyStimulus(3, 64'hEE, 2, 1'b0);
        checkOutput("t3 ack", 64'(b8.push_ack), 64'd0);
        step();
        checkOutput("t3 count", 64'(count8), 64'd4);
        checkOutput("t3 slot0", slot8(0), 64'hB0);
        checkOutput("t3 slot1", slot8(1), 64'hB1);
        checkOutput("t3 err", 64'(err8), 64'(ERR_ON));

        // Build count=5, then flush with push/pop pending
        applyStimulus(1, 64'hD0, 0, 1'b0);
        step();
        checkOutput("t5 pre count", 64'(count8), 64'd5);
        applyStimulus(4, 64'hE0, 2, 1'b1);
        checkOutput("t5 ack formula", 64'(b8.push_ack), 64'd0);
        step();
        checkOutput("t5 count", 64'(count8), 64'd0);
        checkOutput("t5 free", 64'(free8), 64'd8);
        checkOutput("t5 out_num", 64'(b8.out_num), 64'd0);
        checkOutput("t5 out_data", b8.out_data[63:0] | b8.out_data[127:64], 64'd0);
        checkOutput("t5 err kept", 64'(err8), 64'(ERR_ON));
        applyStimulus(1, 64'hC0, 0, 1'b0);
        step();
        checkOutput("t5 c0 out_num", 64'(b8.out_num), 64'd1);
        checkOutput("t5 c0 slot0", slot8(0), 64'hC0);
        checkOutput("t5 c0 slot1 zero", slot8(1), 64'd0);

        // Mid-operation asynchronous reset
        applyStimulus(4, 64'hE0, 0, 1'b0);
        step();
        applyStimulus(0, 64'h0, 0, 1'b0);
        checkOutput("t6 pre count", 64'(count8), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6 count", 64'(count8), 64'd0);
        checkOutput("t6 out_num", 64'(b8.out_num), 64'd0);
        checkOutput("t6 out_data", b8.out_data[63:0] | b8.out_data[127:64], 64'd0);
        checkOutput("t6 err", 64'(err8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4, 64'hF0, 0, 1'b0);
        checkOutput("t6 ack", 64'(b8.push_ack), 64'd1);
        step();
        checkOutput("t6 post count", 64'(count8), 64'd4);

        // Fill to full, reject while full, pop proceeds
        applyStimulus(4, 64'hF4, 0, 1'b0);
        step();
        checkOutput("full count", 64'(count8), 64'd8);
        checkOutput("full free", 64'(free8), 64'd0);
        applyStimulus(1, 64'h99, 2, 1'b0);
        checkOutput("full ack", 64'(b8.push_ack), 64'd0);
        step();
        checkOutput("full pop count", 64'(count8), 64'd6);
        checkOutput("full slot0", slot8(0), 64'hF2);
        checkOutput("full slot1", slot8(1), 64'hF3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 64'h0, 2, 1'b0);
            step();
        end
        checkOutput("drain count", 64'(count8), 64'd0);
        applyStimulus(0, 64'h0, 2, 1'b0);
        step();
        checkOutput("empty clip count", 64'(count8), 64'd0);
        checkOutput("empty clip free", 64'(free8), 64'd8);
        checkOutput("empty clip err", 64'(err8), 64'(ERR_ON));
        applyStimulus(0, 64'h0, 0, 1'b0);

        // Wrap-around on the DEPTH=7 instance against a queue model
        seq = 64'h100;
        for (int c = 0; c < 10; c++) begin
            b7.push_num = PNW'(4);
            for (int i = 0; i < 4; i++) b7.push_data[i*64 +: 64] = seq + 64'(i);
            b7.pop_num = ONW'(2);
            #1;
            exp_ack = (4 <= 7 - q.size());
            exp_on = (q.size() < 2) ? q.size() : 2;
            checkOutput($sformatf("wrap ack c%0d", c), 64'(b7.push_ack), 64'(exp_ack));
            checkOutput($sformatf("wrap out_num c%0d", c), 64'(b7.out_num), 64'(exp_on));
            for (int j = 0; j < exp_on; j++)
                checkOutput($sformatf("wrap slot%0d c%0d", j, c), slot7(j), q[j]);
            pops = exp_on;
            for (int p = 0; p < pops; p++) void'(q.pop_front());
            if (exp_ack) begin
                for (int i = 0; i < 4; i++) q.push_back(seq + 64'(i));
                seq = seq + 64'd4;
            end
            step();
            checkOutput($sformatf("wrap count c%0d", c), 64'(count7), 64'(q.size()));
            checkOutput($sformatf("wrap free c%0d", c), 64'(free7), 64'(7 - q.size()));
        end
        b7.push_num = '0;
        b7.pop_num = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
